// File: rtl/simd_decode_stage.sv
// Instruction FIFO feeding a decode/output register with valid/ready handoff.
// A RET halts issue until flush; illegal words are counted with saturation.
module simd_decode_stage #(
    parameter int DEPTH = 4,
    parameter int IMM_W = 32,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_type,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_rn,
    output logic [4:0]               out_rm,
    output logic [5:0]               out_shamt,
    output logic [8:0]               out_addr,
    output logic [IMM_W-1:0]         out_imm,
    output logic                     out_illegal,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNT_W-1:0]         illegal_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    logic [31:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    state_t           state_q, state_d;
    logic             out_valid_q;
    logic [3:0]       out_type_q;
    logic             out_illegal_q;
    logic [21:0]      out_word_q;
    logic [CNT_W-1:0] illegal_cnt_q;

    logic [31:0] head;
    logic [3:0]  dec_type;
    logic        dec_illegal;
    logic        push, pop, is_run;

    assign head = mem_q[rd_ptr_q];

    // Head is read asynchronously so a word pushed in cycle N can issue in N+2.
    always_comb begin
        dec_type    = 4'd15;
        dec_illegal = 1'b0;
        if (head[31:21] == 11'b0)
            dec_type = 4'd0;
        else if (head[31:21] == 11'b11001011000)
            dec_type = 4'd1;
        else if (head[31:21] == 11'b10011011000)
            dec_type = 4'd2;
        else if (head[31:21] == 11'b10001011000)
            dec_type = 4'd3;
        else if (head[31:21] == 11'b00011110011 && head[15:10] == 6'b001010)
            dec_type = 4'd4;
        else if (head[31:21] == 11'b00011110011 && head[15:10] == 6'b001110)
            dec_type = 4'd5;
        else if (head[31:21] == 11'b10101010101)
            dec_type = 4'd6;
        else if (head[31:22] == 10'b1001000100)
            dec_type = 4'd7;
        else if (head[31:21] == 11'b11010110010)
            dec_type = 4'd8;
        else
            dec_illegal = 1'b1;
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = RUN;
        else if (pop && dec_type == 4'd8)
            state_d = HALTED;
    end

    // FSM: outputs and handshake qualifiers
    always_comb begin
        is_run   = (state_q == RUN);
        halted   = (state_q == HALTED);
        in_ready = (count_q != FULL_CNT) && is_run && !flush;
        push     = in_valid && in_ready;
        pop      = is_run && (count_q != '0) && (!out_valid_q || out_ready) && !flush;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= in_instr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_type_q    <= 4'd0;
            out_illegal_q <= 1'b0;
            out_word_q    <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (pop) begin
            out_valid_q   <= 1'b1;
            out_type_q    <= dec_type;
            out_illegal_q <= dec_illegal;
            out_word_q    <= head[21:0];
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            illegal_cnt_q <= '0;
        else if (pop && dec_illegal && illegal_cnt_q != {CNT_W{1'b1}})
            illegal_cnt_q <= illegal_cnt_q + 1'b1;
    end

    assign out_valid   = out_valid_q;
    assign out_type    = out_type_q;
    assign out_illegal = out_illegal_q;
    assign out_rd      = out_word_q[4:0];
    assign out_rn      = out_word_q[9:5];
    assign out_rm      = out_word_q[20:16];
    assign out_shamt   = out_word_q[15:10];
    assign out_addr    = out_word_q[20:12];
    assign out_imm     = IMM_W'(out_word_q[21:10]);
    assign occupancy   = count_q;
    assign illegal_cnt = illegal_cnt_q;
endmodule
